// File: rtl/exu_div_core.sv
// Integer divide slice for slot I0: radix-2 restoring divider on operand
// magnitudes, 32 iterations plus a sign-fix step, with an optional fast finish.
module exu_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            dec_tlu_fast_div_disable,
  input  logic            dec_i0_div_d,
  input  logic            div_p_valid,
  input  logic            div_p_unsign,
  input  logic            div_p_rem,
  input  logic [XLEN-1:0] gpr_i0_rs1_d,
  input  logic [XLEN-1:0] gpr_i0_rs2_d,
  input  logic            dec_tlu_flush_lower_wb,
  output logic [XLEN-1:0] exu_div_result,
  output logic            exu_div_finish,
  output logic            exu_div_stall
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [2:0] {IDLE, FAST, RUN, FIX, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] a_q;      // dividend magnitude, shifts into quotient
  logic [XLEN-1:0] b_q;      // divisor magnitude
  logic [XLEN-1:0] r_q;      // partial remainder
  logic [XLEN-1:0] stage_q;
  logic [XLEN-1:0] result_q;
  logic            finish_q, stall_q;
  logic            rem_q, s1_q, s2_q, dz_q;

  logic            start;
  logic            fast_ok;
  logic [XLEN-1:0] mag1, mag2;
  logic [XLEN:0]   r_sh, diff;
  logic [XLEN-1:0] q_fix, r_fix, rs1_back;

  always_comb begin
    start    = dec_i0_div_d & div_p_valid;
    mag1     = (!div_p_unsign && gpr_i0_rs1_d[XLEN-1]) ? -gpr_i0_rs1_d : gpr_i0_rs1_d;
    mag2     = (!div_p_unsign && gpr_i0_rs2_d[XLEN-1]) ? -gpr_i0_rs2_d : gpr_i0_rs2_d;
    fast_ok  = !dec_tlu_fast_div_disable &&
               ((gpr_i0_rs2_d == '0) || (mag1 < mag2));
    r_sh     = {r_q, a_q[XLEN-1]};
    diff     = r_sh - {1'b0, b_q};
    q_fix    = (s1_q ^ s2_q) ? -a_q : a_q;
    r_fix    = s1_q ? -r_q : r_q;
    // On the fast path a_q still holds |rs1|; re-applying the sign recovers rs1.
    rs1_back = s1_q ? -a_q : a_q;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      stage_q  <= '0;
      result_q <= '0;
      finish_q <= 1'b0;
      stall_q  <= 1'b0;
      rem_q    <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      dz_q     <= 1'b0;
    end else if (dec_tlu_flush_lower_wb) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      finish_q <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      // Stall covers the finish cycle itself, then drops unless a new op starts.
      if (finish_q) stall_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= mag1;
            b_q     <= mag2;
            r_q     <= '0;
            cnt_q   <= '0;
            rem_q   <= div_p_rem;
            s1_q    <= !div_p_unsign && gpr_i0_rs1_d[XLEN-1];
            s2_q    <= !div_p_unsign && gpr_i0_rs2_d[XLEN-1];
            dz_q    <= (gpr_i0_rs2_d == '0);
            stall_q <= 1'b1;
            state_q <= fast_ok ? FAST : RUN;
          end
        end
        FAST: begin
          stage_q <= rem_q ? rs1_back : (dz_q ? '1 : '0);
          state_q <= DONE;
        end
        RUN: begin
          if (!diff[XLEN]) begin
            r_q <= diff[XLEN-1:0];
            a_q <= {a_q[XLEN-2:0], 1'b1};
          end else begin
            r_q <= r_sh[XLEN-1:0];
            a_q <= {a_q[XLEN-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= FIX;
        end
        FIX: begin
          stage_q <= rem_q ? r_fix : (dz_q ? '1 : q_fix);
          state_q <= DONE;
        end
        DONE: begin
          result_q <= stage_q;
          finish_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign exu_div_result = result_q;
  assign exu_div_finish = finish_q;
  assign exu_div_stall  = stall_q;

endmodule

// File: tb/tb_exu_div_core.sv
// Directed bench for exu_div_core: results, finish timing, stall window,
// flush and asynchronous reset behaviour.
module tb_exu_div_core;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        dec_tlu_fast_div_disable;
  logic        dec_i0_div_d;
  logic        div_p_valid;
  logic        div_p_unsign;
  logic        div_p_rem;
  logic [31:0] gpr_i0_rs1_d;
  logic [31:0] gpr_i0_rs2_d;
  logic        dec_tlu_flush_lower_wb;
  logic [31:0] exu_div_result;
  logic        exu_div_finish;
  logic        exu_div_stall;

  int n_checks = 0;
  int n_fail   = 0;

  exu_div_core #(.XLEN(32)) dut (
    .clk                      (clk),
    .rst_l                    (rst_l),
    .dec_tlu_fast_div_disable (dec_tlu_fast_div_disable),
    .dec_i0_div_d             (dec_i0_div_d),
    .div_p_valid              (div_p_valid),
    .div_p_unsign             (div_p_unsign),
    .div_p_rem                (div_p_rem),
    .gpr_i0_rs1_d             (gpr_i0_rs1_d),
    .gpr_i0_rs2_d             (gpr_i0_rs2_d),
    .dec_tlu_flush_lower_wb   (dec_tlu_flush_lower_wb),
    .exu_div_result           (exu_div_result),
    .exu_div_finish           (exu_div_finish),
    .exu_div_stall            (exu_div_stall)
  );

  always #5 clk = ~clk;

  // Launches one op from a negedge and observes `win` following negedges.
  // k counts negedges after the start edge; finish after edge T0+34 is k=35.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic uns, input logic rm, input logic fdis,
                        input int win, output int fin_k, output int fin_n,
                        output logic [31:0] res, output int st_n, output int st_low);
    fin_k = 0; fin_n = 0; res = '0; st_n = 0; st_low = 0;
    gpr_i0_rs1_d = a; gpr_i0_rs2_d = b; div_p_unsign = uns; div_p_rem = rm;
    dec_tlu_fast_div_disable = fdis; dec_i0_div_d = 1'b1; div_p_valid = 1'b1;
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      if (k == 1) begin dec_i0_div_d = 1'b0; div_p_valid = 1'b0; end
      if (exu_div_finish) begin
        fin_n++;
        if (fin_k == 0) begin fin_k = k; res = exu_div_result; end
      end
      if (exu_div_stall) st_n++;
      else if (st_low == 0) st_low = k;
    end
  endtask

  task automatic test_reset();
    rst_l = 1'b0; dec_tlu_fast_div_disable = 1'b0; dec_i0_div_d = 1'b0;
    div_p_valid = 1'b0; div_p_unsign = 1'b0; div_p_rem = 1'b0;
    gpr_i0_rs1_d = '0; gpr_i0_rs2_d = '0; dec_tlu_flush_lower_wb = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (exu_div_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=%h", exu_div_result, 32'h0); end
    n_checks++; if (exu_div_finish !== 1'b0) begin n_fail++; $display("FAIL reset_finish got=%b exp=0", exu_div_finish); end
    n_checks++; if (exu_div_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", exu_div_stall); end
    rst_l = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int fk, fn, sn, sl; logic [31:0] r;
    run_op(32'h100, 32'h2, 1'b1, 1'b0, 1'b1, 40, fk, fn, r, sn, sl);
    n_checks++; if (fk !== 35) begin n_fail++; $display("FAIL udiv_latency got=%0d exp=35", fk); end
    n_checks++; if (fn !== 1) begin n_fail++; $display("FAIL udiv_finish_count got=%0d exp=1", fn); end
    n_checks++; if (r !== 32'h80) begin n_fail++; $display("FAIL udiv_result got=%h exp=%h", r, 32'h80); end
    n_checks++; if (sn !== 35) begin n_fail++; $display("FAIL udiv_stall_cycles got=%0d exp=35", sn); end
    n_checks++; if (sl !== 36) begin n_fail++; $display("FAIL udiv_stall_drop got=%0d exp=36", sl); end
    run_op(32'hFFFFFFFF, 32'h10, 1'b1, 1'b0, 1'b0, 40, fk, fn, r, sn, sl);
    n_checks++; if (r !== 32'h0FFFFFFF) begin n_fail++; $display("FAIL udiv_big got=%h exp=%h", r, 32'h0FFFFFFF); end
    n_checks++; if (fk !== 35) begin n_fail++; $display("FAIL udiv_big_latency got=%0d exp=35", fk); end
    run_op(32'hFFFFFFFF, 32'h10, 1'b1, 1'b1, 1'b0, 40, fk, fn, r, sn, sl);
    n_checks++; if (r !== 32'hF) begin n_fail++; $display("FAIL urem_big got=%h exp=%h", r, 32'hF); end
  endtask

  task automatic test_signed();
    int fk, fn, sn, sl; logic [31:0] r;
    run_op(32'hFFFFFFF9, 32'h2, 1'b0, 1'b0, 1'b1, 40, fk, fn, r, sn, sl);
    n_checks++; if (r !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL sdiv_m7_2 got=%h exp=%h", r, 32'hFFFFFFFD); end
    run_op(32'hFFFFFFF9, 32'h2, 1'b0, 1'b1, 1'b1, 40, fk, fn, r, sn, sl);
    n_checks++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL srem_m7_2 got=%h exp=%h", r, 32'hFFFFFFFF); end
    run_op(32'd100, 32'hFFFFFFF9, 1'b0, 1'b0, 1'b0, 40, fk, fn, r, sn, sl);
    n_checks++; if (r !== 32'hFFFFFFF2) begin n_fail++; $display("FAIL sdiv_100_m7 got=%h exp=%h", r, 32'hFFFFFFF2); end
    run_op(32'd100, 32'hFFFFFFF9, 1'b0, 1'b1, 1'b0, 40, fk, fn, r, sn, sl);
    n_checks++; if (r !== 32'h2) begin n_fail++; $display("FAIL srem_100_m7 got=%h exp=%h", r, 32'h2); end
    run_op(32'hFFFFFF9C, 32'h7, 1'b0, 1'b1, 1'b0, 40, fk, fn, r, sn, sl);
    n_checks++; if (r !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL srem_m100_7 got=%h exp=%h", r, 32'hFFFFFFFE); end
  endtask

  task automatic test_div_zero();
    int fk, fn, sn, sl; logic [31:0] r;
    run_op(32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 40, fk, fn, r, sn, sl);
    n_checks++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dz_sdiv_slow got=%h exp=%h", r, 32'hFFFFFFFF); end
    n_checks++; if (fk !== 35) begin n_fail++; $display("FAIL dz_slow_latency got=%0d exp=35", fk); end
    run_op(32'h1234, 32'h0, 1'b1, 1'b1, 1'b1, 40, fk, fn, r, sn, sl);
    n_checks++; if (r !== 32'h1234) begin n_fail++; $display("FAIL dz_urem_slow got=%h exp=%h", r, 32'h1234); end
    run_op(32'h1234, 32'h0, 1'b1, 1'b0, 1'b0, 40, fk, fn, r, sn, sl);
    n_checks++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dz_udiv_fast got=%h exp=%h", r, 32'hFFFFFFFF); end
    n_checks++; if (fk !== 3) begin n_fail++; $display("FAIL dz_fast_latency got=%0d exp=3", fk); end
    n_checks++; if (sn !== 3) begin n_fail++; $display("FAIL dz_fast_stall_cycles got=%0d exp=3", sn); end
    n_checks++; if (fn !== 1) begin n_fail++; $display("FAIL dz_fast_finish_count got=%0d exp=1", fn); end
    run_op(32'h1234, 32'h0, 1'b0, 1'b1, 1'b0, 40, fk, fn, r, sn, sl);
    n_checks++; if (r !== 32'h1234) begin n_fail++; $display("FAIL dz_srem_fast got=%h exp=%h", r, 32'h1234); end
    run_op(32'hFFFFFF00, 32'h0, 1'b0, 1'b1, 1'b1, 40, fk, fn, r, sn, sl);
    n_checks++; if (r !== 32'hFFFFFF00) begin n_fail++; $display("FAIL dz_srem_neg got=%h exp=%h", r, 32'hFFFFFF00); end
    run_op(32'hFFFFFF00, 32'h0, 1'b0, 1'b0, 1'b1, 40, fk, fn, r, sn, sl);
    n_checks++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dz_sdiv_neg got=%h exp=%h", r, 32'hFFFFFFFF); end
  endtask

  task automatic test_overflow();
    int fk, fn, sn, sl; logic [31:0] r;
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 40, fk, fn, r, sn, sl);
    n_checks++; if (r !== 32'h80000000) begin n_fail++; $display("FAIL ovf_div got=%h exp=%h", r, 32'h80000000); end
    n_checks++; if (fk !== 35) begin n_fail++; $display("FAIL ovf_latency got=%0d exp=35", fk); end
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 40, fk, fn, r, sn, sl);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL ovf_rem got=%h exp=%h", r, 32'h0); end
  endtask

  task automatic test_fast_path();
    int fk, fn, sn, sl; logic [31:0] r;
    run_op(32'hFFFFFFFD, 32'h5, 1'b0, 1'b1, 1'b0, 40, fk, fn, r, sn, sl);
    n_checks++; if (r !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL fast_srem got=%h exp=%h", r, 32'hFFFFFFFD); end
    n_checks++; if (fk !== 3) begin n_fail++; $display("FAIL fast_srem_latency got=%0d exp=3", fk); end
    run_op(32'hFFFFFFFD, 32'h5, 1'b0, 1'b0, 1'b0, 40, fk, fn, r, sn, sl);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL fast_sdiv got=%h exp=%h", r, 32'h0); end
    run_op(32'hFFFFFFFD, 32'h5, 1'b0, 1'b1, 1'b1, 40, fk, fn, r, sn, sl);
    n_checks++; if (fk !== 35) begin n_fail++; $display("FAIL fast_disabled_latency got=%0d exp=35", fk); end
    n_checks++; if (r !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL fast_disabled_rem got=%h exp=%h", r, 32'hFFFFFFFD); end
    run_op(32'h3, 32'hFFFFFFFD, 1'b1, 1'b1, 1'b0, 40, fk, fn, r, sn, sl);
    n_checks++; if (fk !== 3) begin n_fail++; $display("FAIL fast_unsigned_latency got=%0d exp=3", fk); end
    run_op(32'h100, 32'h2, 1'b1, 1'b0, 1'b0, 40, fk, fn, r, sn, sl);
    n_checks++; if (fk !== 35) begin n_fail++; $display("FAIL fast_not_applicable got=%0d exp=35", fk); end
  endtask

  task automatic test_flush();
    int fn, st11, fk, sn, sl; logic [31:0] r;
    fn = 0; st11 = -1;
    gpr_i0_rs1_d = 32'h100; gpr_i0_rs2_d = 32'h2; div_p_unsign = 1'b1; div_p_rem = 1'b0;
    dec_tlu_fast_div_disable = 1'b1; dec_i0_div_d = 1'b1; div_p_valid = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) begin dec_i0_div_d = 1'b0; div_p_valid = 1'b0; end
      if (exu_div_finish) fn++;
      if (k == 11) begin st11 = int'(exu_div_stall); dec_tlu_flush_lower_wb = 1'b0; end
      if (k == 10) dec_tlu_flush_lower_wb = 1'b1;
    end
    n_checks++; if (st11 !== 0) begin n_fail++; $display("FAIL flush_stall_drop got=%0d exp=0", st11); end
    n_checks++; if (fn !== 0) begin n_fail++; $display("FAIL flush_no_finish got=%0d exp=0", fn); end
    run_op(32'd9, 32'd3, 1'b1, 1'b0, 1'b1, 40, fk, fn, r, sn, sl);
    n_checks++; if (r !== 32'h3) begin n_fail++; $display("FAIL after_flush_result got=%h exp=%h", r, 32'h3); end
    n_checks++; if (fk !== 35) begin n_fail++; $display("FAIL after_flush_latency got=%0d exp=35", fk); end
  endtask

  task automatic test_flush_on_start();
    int fn, sn;
    fn = 0; sn = 0;
    gpr_i0_rs1_d = 32'h55; gpr_i0_rs2_d = 32'h0; div_p_unsign = 1'b1; div_p_rem = 1'b0;
    dec_tlu_fast_div_disable = 1'b0; dec_i0_div_d = 1'b1; div_p_valid = 1'b1;
    dec_tlu_flush_lower_wb = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin dec_i0_div_d = 1'b0; div_p_valid = 1'b0; dec_tlu_flush_lower_wb = 1'b0; end
      if (exu_div_finish) fn++;
      if (exu_div_stall) sn++;
    end
    n_checks++; if (fn !== 0) begin n_fail++; $display("FAIL flush_start_finish got=%0d exp=0", fn); end
    n_checks++; if (sn !== 0) begin n_fail++; $display("FAIL flush_start_stall got=%0d exp=0", sn); end
  endtask

  task automatic test_back_to_back();
    int k1, k2, st_after; logic [31:0] r1, r2;
    k1 = 0; k2 = 0; st_after = -1; r1 = '0; r2 = '0;
    gpr_i0_rs1_d = 32'd20; gpr_i0_rs2_d = 32'd4; div_p_unsign = 1'b1; div_p_rem = 1'b0;
    dec_tlu_fast_div_disable = 1'b1; dec_i0_div_d = 1'b1; div_p_valid = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 1 || (k1 != 0 && k == k1 + 1)) begin dec_i0_div_d = 1'b0; div_p_valid = 1'b0; end
      if (k1 != 0 && k == k1 + 1) st_after = int'(exu_div_stall);
      if (exu_div_finish && k1 == 0) begin
        k1 = k; r1 = exu_div_result;
        gpr_i0_rs1_d = 32'd100; gpr_i0_rs2_d = 32'd7;
        dec_i0_div_d = 1'b1; div_p_valid = 1'b1;
      end else if (exu_div_finish && k2 == 0) begin
        k2 = k; r2 = exu_div_result;
      end
    end
    dec_i0_div_d = 1'b0; div_p_valid = 1'b0;
    n_checks++; if (k1 !== 35) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=35", k1); end
    n_checks++; if (r1 !== 32'd5) begin n_fail++; $display("FAIL b2b_first_result got=%h exp=%h", r1, 32'd5); end
    n_checks++; if (st_after !== 1) begin n_fail++; $display("FAIL b2b_stall_held got=%0d exp=1", st_after); end
    n_checks++; if (k2 !== 70) begin n_fail++; $display("FAIL b2b_second_at got=%0d exp=70", k2); end
    n_checks++; if (r2 !== 32'd14) begin n_fail++; $display("FAIL b2b_second_result got=%h exp=%h", r2, 32'd14); end
  endtask

  task automatic test_reset_mid_op();
    int fn, sn;
    fn = 0; sn = 0;
    gpr_i0_rs1_d = 32'h100; gpr_i0_rs2_d = 32'h2; div_p_unsign = 1'b1; div_p_rem = 1'b0;
    dec_tlu_fast_div_disable = 1'b1; dec_i0_div_d = 1'b1; div_p_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin dec_i0_div_d = 1'b0; div_p_valid = 1'b0; end
    end
    rst_l = 1'b0;
    #1;
    n_checks++; if (exu_div_result !== 32'h0) begin n_fail++; $display("FAIL rst_mid_result got=%h exp=%h", exu_div_result, 32'h0); end
    n_checks++; if (exu_div_stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall got=%b exp=0", exu_div_stall); end
    n_checks++; if (exu_div_finish !== 1'b0) begin n_fail++; $display("FAIL rst_mid_finish got=%b exp=0", exu_div_finish); end
    @(negedge clk);
    rst_l = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (exu_div_finish) fn++;
      if (exu_div_stall) sn++;
    end
    n_checks++; if (fn !== 0) begin n_fail++; $display("FAIL rst_mid_no_finish got=%0d exp=0", fn); end
    n_checks++; if (sn !== 0) begin n_fail++; $display("FAIL rst_mid_no_stall got=%0d exp=0", sn); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_fast_path();
    test_flush();
    test_flush_on_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
